// File: rtl/cv32e41s_instr_prefetch_ctrl_if.sv
// Fetch-request, response and instruction-output bundle of the prefetch controller.
// master = prefetch controller, slave = OBI adapter plus IF stage.
interface cv32e41s_instr_prefetch_ctrl_if;
   logic        trans_valid_o;
   logic        trans_ready_i;
   logic [31:0] trans_addr_o;
   logic        resp_valid_i;
   logic [31:0] resp_rdata_i;
   logic        resp_err_i;
   logic        resp_integrity_err_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_rdata_o;
   logic [31:0] instr_addr_o;
   logic        instr_err_o;

   modport master (
      output trans_valid_o, trans_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o, instr_err_o,
      input  trans_ready_i, resp_valid_i, resp_rdata_i, resp_err_i, resp_integrity_err_i,
             instr_ready_i
   );

   modport slave (
      input  trans_valid_o, trans_addr_o, instr_valid_o, instr_rdata_o, instr_addr_o, instr_err_o,
      output trans_ready_i, resp_valid_i, resp_rdata_i, resp_err_i, resp_integrity_err_i,
             instr_ready_i
   );
endinterface

// File: rtl/cv32e41s_instr_prefetch_ctrl.sv
// Sequential word prefetcher: credit-limited fetch requests, in-order response FIFO,
// branch flush with discard of in-flight responses, halt on error until the next branch.
module cv32e41s_instr_prefetch_ctrl #(
   parameter int unsigned DEPTH           = 3,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  fetch_enable_i,
   input  logic                                  branch_i,
   input  logic [31:0]                           branch_addr_i,
   output logic                                  busy_o,
   cv32e41s_instr_prefetch_ctrl_if.master        bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;

   state_e          r_state, w_state_nxt;
   logic [31:0]     r_fetch_addr, r_resp_addr;
   logic [CW-1:0]   r_outstanding, r_discard, r_count;
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [31:0]     r_mem_data [DEPTH];
   logic [31:0]     r_mem_addr [DEPTH];
   logic [DEPTH-1:0] r_mem_err;
   logic [31:0]     r_hold_data, r_hold_addr;
   logic            r_hold_err;

   logic            w_hs, w_resp, w_push, w_pop, w_resp_err, w_credit, w_empty;
   logic [CW:0]     w_inflight;
   logic [31:0]     w_branch_addr;
   logic            w_unused;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_unused      = ^branch_addr_i[1:0];
   assign w_branch_addr = {branch_addr_i[31:2], 2'b00};
   assign w_empty       = (r_count == '0);

   // Words already requested count against FIFO space, so a push can never find it full.
   assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_credit   = (w_inflight < (CW+1)'(DEPTH));

   assign bus.trans_valid_o = (r_state == S_RUN) && fetch_enable_i && !branch_i &&
                              (r_outstanding < CW'(MAX_OUTSTANDING)) && w_credit;
   assign bus.trans_addr_o  = r_fetch_addr;

   assign w_hs       = bus.trans_valid_o && bus.trans_ready_i;
   assign w_resp     = bus.resp_valid_i && (r_outstanding != '0);
   assign w_resp_err = bus.resp_err_i || bus.resp_integrity_err_i;
   assign w_push     = w_resp && !branch_i && (r_discard == '0) && (r_state == S_RUN);
   assign w_pop      = !w_empty && bus.instr_ready_i && !branch_i;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (branch_i) w_state_nxt = S_RUN;
         S_RUN:   if (w_push && w_resp_err) w_state_nxt = S_HALT;
         S_HALT:  if (branch_i) w_state_nxt = S_RUN;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_addr  <= '0;
         r_resp_addr   <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(w_hs) - CW'(w_resp);
         if (branch_i) begin
            r_fetch_addr <= w_branch_addr;
            r_resp_addr  <= w_branch_addr;
            // Everything still in flight belongs to the old stream.
            r_discard    <= r_outstanding - CW'(w_resp);
         end else begin
            if (w_hs)                       r_fetch_addr <= r_fetch_addr + 32'd4;
            if (w_push)                     r_resp_addr  <= r_resp_addr + 32'd4;
            if (w_resp && r_discard != '0)  r_discard    <= r_discard - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_mem_err   <= '0;
         r_hold_data <= '0;
         r_hold_addr <= '0;
         r_hold_err  <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem_data[i] <= '0;
            r_mem_addr[i] <= '0;
         end
      end else begin
         // Remember what is on the outputs so they hold once the FIFO empties.
         if (!w_empty) begin
            r_hold_data <= r_mem_data[r_rptr];
            r_hold_addr <= r_mem_addr[r_rptr];
            r_hold_err  <= r_mem_err[r_rptr];
         end
         if (branch_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_mem_data[r_wptr] <= bus.resp_rdata_i;
               r_mem_addr[r_wptr] <= r_resp_addr;
               r_mem_err[r_wptr]  <= w_resp_err;
               r_wptr             <= f_inc(r_wptr);
            end
            if (w_pop) r_rptr <= f_inc(r_rptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
         end
      end
   end

   assign bus.instr_valid_o = !w_empty;
   assign bus.instr_rdata_o = w_empty ? r_hold_data : r_mem_data[r_rptr];
   assign bus.instr_addr_o  = w_empty ? r_hold_addr : r_mem_addr[r_rptr];
   assign bus.instr_err_o   = w_empty ? r_hold_err  : r_mem_err[r_rptr];
   assign busy_o            = (r_outstanding != '0) || !w_empty;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (r_count == CW'(DEPTH))));
endmodule

// File: tb/tb_cv32e41s_instr_prefetch_ctrl.sv
// Directed bench: a 1-cycle-latency adapter model feeds responses; handshakes and pops are logged
// and compared against hand-derived addresses, data tags and flags.
module tb_cv32e41s_instr_prefetch_ctrl;
   logic        clk = 1'b0;
   logic        rst_n, fetch_enable, branch, busy;
   logic [31:0] branch_addr;

   cv32e41s_instr_prefetch_ctrl_if bus();

   cv32e41s_instr_prefetch_ctrl #(.DEPTH(3), .MAX_OUTSTANDING(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_enable_i(fetch_enable),
      .branch_i      (branch),
      .branch_addr_i (branch_addr),
      .busy_o        (busy),
      .bus           (bus.master)
   );

   always #5 clk = ~clk;

   int          n_vec, n_err, seq, tb_out, max_out, ss;
   logic        hold_resp;
   logic [31:0] err_addr;
   logic [31:0] aq[$], dq[$], hs_log[$], pa[$], pd[$], pe[$];
   logic        s_tvalid, s_ivalid, s_ierr, s_busy;
   logic [31:0] s_iaddr;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
   endfunction

   // One clock: present adapter response, sample mid-cycle, advance to posedge+1.
   task automatic step();
      logic [31:0] a;
      if (!hold_resp && aq.size() != 0) begin
         a = aq.pop_front();
         bus.resp_valid_i = 1'b1;
         bus.resp_rdata_i = dq.pop_front();
         bus.resp_err_i   = (a == err_addr);
         tb_out--;
      end else begin
         bus.resp_valid_i = 1'b0;
         bus.resp_rdata_i = '0;
         bus.resp_err_i   = 1'b0;
      end
      #4;
      s_tvalid = bus.trans_valid_o;
      s_ivalid = bus.instr_valid_o;
      s_iaddr  = bus.instr_addr_o;
      s_ierr   = bus.instr_err_o;
      s_busy   = busy;
      if (bus.trans_valid_o && bus.trans_ready_i) begin
         hs_log.push_back(bus.trans_addr_o);
         aq.push_back(bus.trans_addr_o);
         dq.push_back(32'hD000_0000 | seq);
         seq++;
         tb_out++;
         if (tb_out > max_out) max_out = tb_out;
      end
      if (bus.instr_valid_o && bus.instr_ready_i) begin
         pa.push_back(bus.instr_addr_o);
         pd.push_back(bus.instr_rdata_o);
         pe.push_back({31'd0, bus.instr_err_o});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_branch(input logic [31:0] addr);
      branch      = 1'b1;
      branch_addr = addr;
      step();
      branch = 1'b0;
      hs_log.delete();
      pa.delete();
      pd.delete();
      pe.delete();
   endtask

   initial begin
      n_vec = 0; n_err = 0; seq = 0; tb_out = 0; max_out = 0; ss = 0;
      rst_n = 1'b0; fetch_enable = 1'b0; branch = 1'b0; branch_addr = '0;
      hold_resp = 1'b0; err_addr = 32'h1;
      bus.trans_ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.resp_rdata_i = '0;
      bus.resp_err_i = 1'b0; bus.resp_integrity_err_i = 1'b0; bus.instr_ready_i = 1'b0;

      repeat (2) @(posedge clk);
      #4;
      chk("rst trans_valid", {31'd0, bus.trans_valid_o}, 32'd0);
      chk("rst trans_addr",  bus.trans_addr_o, 32'd0);
      chk("rst instr_valid", {31'd0, bus.instr_valid_o}, 32'd0);
      chk("rst instr_rdata", bus.instr_rdata_o, 32'd0);
      chk("rst instr_addr",  bus.instr_addr_o, 32'd0);
      chk("rst instr_err",   {31'd0, bus.instr_err_o}, 32'd0);
      chk("rst busy",        {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      fetch_enable = 1'b1;
      bus.trans_ready_i = 1'b1;
      bus.instr_ready_i = 1'b1;

      // IDLE never fetches without a branch
      repeat (2) step();
      chk("idle no request", hs_log.size(), 32'd0);

      // sequential stream from 0x80
      do_branch(32'h80);
      repeat (6) step();
      chk("seq req3 addr", at(hs_log, 3), 32'h8C);
      chk("seq pop0 addr", at(pa, 0), 32'h80);
      chk("seq pop1 addr", at(pa, 1), 32'h84);
      chk("seq pop2 addr", at(pa, 2), 32'h88);
      chk("seq pop0 data", at(pd, 0), 32'hD000_0000);
      chk("seq pop1 data", at(pd, 1), 32'hD000_0001);

      // branch while a response arrives and the head pops
      do_branch(32'h300);
      ss = seq;
      step();
      chk("brpop instr_valid", {31'd0, s_ivalid}, 32'd0);
      chk("brpop busy", {31'd0, s_busy}, 32'd0);
      chk("brpop trans_valid", {31'd0, s_tvalid}, 32'd1);
      repeat (3) step();
      chk("brpop first addr", at(pa, 0), 32'h300);
      chk("brpop first data", at(pd, 0), 32'hD000_0000 | ss);

      // stalled adapter: outstanding caps at 2
      hold_resp = 1'b1;
      repeat (3) step();
      chk("cap trans_valid", {31'd0, s_tvalid}, 32'd0);
      chk("cap max outstanding", max_out, 32'd2);
      hold_resp = 1'b0;

      // IF stalled: three words stored, then one pop frees one credit
      bus.instr_ready_i = 1'b0;
      do_branch(32'h400);
      repeat (8) step();
      chk("full req count", hs_log.size(), 32'd3);
      chk("full last req", at(hs_log, 2), 32'h408);
      chk("full trans_valid", {31'd0, s_tvalid}, 32'd0);
      chk("full head addr", s_iaddr, 32'h400);
      bus.instr_ready_i = 1'b1;
      step();
      bus.instr_ready_i = 1'b0;
      repeat (5) step();
      chk("credit req count", hs_log.size(), 32'd4);
      chk("credit new req", at(hs_log, 3), 32'h40C);
      chk("credit popped", at(pa, 0), 32'h400);

      // branch with two outstanding: both old responses discarded
      bus.instr_ready_i = 1'b1;
      hold_resp = 1'b1;
      do_branch(32'h600);
      repeat (3) step();
      chk("disc old reqs", hs_log.size(), 32'd2);
      do_branch(32'h200);
      ss = seq;
      hold_resp = 1'b0;
      repeat (6) step();
      chk("disc first addr", at(pa, 0), 32'h200);
      chk("disc first data", at(pd, 0), 32'hD000_0000 | ss);

      // bus error on 0x88 halts fetching
      err_addr = 32'h88;
      do_branch(32'h80);
      repeat (10) step();
      chk("err req count", hs_log.size(), 32'd4);
      chk("err last req", at(hs_log, 3), 32'h8C);
      chk("err pop count", pa.size(), 32'd3);
      chk("err pop1 flag", at(pe, 1), 32'd0);
      chk("err pop2 addr", at(pa, 2), 32'h88);
      chk("err pop2 flag", at(pe, 2), 32'd1);
      chk("halt trans_valid", {31'd0, s_tvalid}, 32'd0);
      chk("halt busy", {31'd0, s_busy}, 32'd0);
      chk("hold err", {31'd0, s_ierr}, 32'd1);
      chk("hold addr", s_iaddr, 32'h88);
      err_addr = 32'h1;
      do_branch(32'h100);
      repeat (3) step();
      chk("restart addr", at(hs_log, 0), 32'h100);

      // address wrap, low bits of the target ignored
      do_branch(32'hFFFF_FFFB);
      repeat (6) step();
      chk("wrap req0", at(hs_log, 0), 32'hFFFF_FFF8);
      chk("wrap req1", at(hs_log, 1), 32'hFFFF_FFFC);
      chk("wrap req2", at(hs_log, 2), 32'h0000_0000);
      chk("wrap pop2 addr", at(pa, 2), 32'h0000_0000);

      // fetch disabled: stream drains and stops
      fetch_enable = 1'b0;
      repeat (4) step();
      hs_log.delete();
      repeat (3) step();
      chk("fe off no req", hs_log.size(), 32'd0);
      chk("fe off busy", {31'd0, s_busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
